// File: rtl/arb_pkg.sv
// Shared definitions for the QoS stream arbiter: default widths, index-width
// helper and the grant controller state type.
package arb_pkg;

  localparam int unsigned DEF_T_DATA_WIDTH = 8;
  localparam int unsigned DEF_T_QOS__WIDTH = 4;
  localparam int unsigned DEF_STREAM_COUNT = 2;

  // Index value meaning "no stream" for the default stream count
  localparam int unsigned NO_STREAM = DEF_STREAM_COUNT;

  // Index width carries one extra bit so STREAM_COUNT itself is representable
  function automatic int unsigned idx_width(input int unsigned n);
    return $clog2(n) + 1;
  endfunction

  typedef enum logic [1:0] {
    CALC,
    SAMPLE,
    XFER
  } grant_state_t;

endpackage

// File: rtl/stream_mux.sv
// Combinational selection of the granted stream onto the master port and
// demux of the master ready back to that stream only.
module stream_mux
  import arb_pkg::*;
#(
  parameter int unsigned T_DATA_WIDTH = DEF_T_DATA_WIDTH,
  parameter int unsigned STREAM_COUNT = DEF_STREAM_COUNT,
  parameter int unsigned SW           = $clog2(DEF_STREAM_COUNT)
) (
  input  logic                                      i_en,
  input  logic [SW-1:0]                             i_sel,
  input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] i_s_data,
  input  logic [STREAM_COUNT-1:0]                   i_s_last,
  input  logic [STREAM_COUNT-1:0]                   i_s_valid,
  input  logic                                      i_m_ready,
  output logic [T_DATA_WIDTH-1:0]                   o_m_data,
  output logic                                      o_m_last,
  output logic                                      o_m_valid,
  output logic [STREAM_COUNT-1:0]                   o_s_ready
);

  always_comb begin
    o_m_data  = '0;
    o_m_last  = 1'b0;
    o_m_valid = 1'b0;
    o_s_ready = '0;
    if (i_en) begin
      o_m_data         = i_s_data[i_sel];
      o_m_last         = i_s_last[i_sel];
      o_m_valid        = i_s_valid[i_sel];
      o_s_ready[i_sel] = i_m_ready;
    end
  end

endmodule

// File: rtl/stream_grant_ctrl.sv
// Grant/forwarding controller: sequences the comparator tree, samples the
// winning stream (zero-QoS first) and forwards its packet until last.
module stream_grant_ctrl
  import arb_pkg::*;
#(
  parameter  int unsigned T_DATA_WIDTH = DEF_T_DATA_WIDTH,
  parameter  int unsigned T_QOS__WIDTH = DEF_T_QOS__WIDTH,
  parameter  int unsigned STREAM_COUNT = DEF_STREAM_COUNT,
  parameter  int unsigned TREE_LAT     = $clog2(STREAM_COUNT),
  localparam int unsigned IW           = idx_width(STREAM_COUNT)
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_i,
  input  logic [STREAM_COUNT-1:0]                   s_last_i,
  input  logic [STREAM_COUNT-1:0]                   s_valid_i,
  output logic [STREAM_COUNT-1:0]                   s_ready_o,
  input  logic [IW-1:0]                             win_index_i,
  input  logic [IW-1:0]                             win_index0_i,
  output logic                                      can_calc_o,
  output logic [STREAM_COUNT-1:0]                   in_serv_o,
  output logic [T_DATA_WIDTH-1:0]                   m_data_o,
  output logic [T_QOS__WIDTH-1:0]                   m_qos_o,
  output logic [IW-2:0]                             m_id_o,
  output logic                                      m_last_o,
  output logic                                      m_valid_o,
  input  logic                                      m_ready_i
);

  localparam int unsigned SW = IW - 1;
  localparam int unsigned CW = (TREE_LAT < 1) ? 1 : $clog2(TREE_LAT + 1);

  grant_state_t            r_state, w_state_nxt;
  logic [CW-1:0]           r_calc_cnt, w_calc_cnt_nxt;
  logic [SW-1:0]           r_sel, w_sel_nxt;
  logic [T_QOS__WIDTH-1:0] r_qos, w_qos_nxt;

  logic          w_cand_ok;
  logic [SW-1:0] w_cand_sel;
  logic          w_xfer;
  logic [T_DATA_WIDTH-1:0] w_m_data;
  logic          w_m_last;
  logic          w_m_valid;

  assign w_xfer = (r_state == XFER);

  // Zero-QoS streams are urgent and take precedence over the max-QoS winner
  always_comb begin
    w_cand_ok  = 1'b0;
    w_cand_sel = '0;
    if (win_index0_i < IW'(STREAM_COUNT)) begin
      w_cand_ok  = 1'b1;
      w_cand_sel = win_index0_i[SW-1:0];
    end else if (win_index_i < IW'(STREAM_COUNT)) begin
      w_cand_ok  = 1'b1;
      w_cand_sel = win_index_i[SW-1:0];
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_calc_cnt_nxt = r_calc_cnt;
    w_sel_nxt      = r_sel;
    w_qos_nxt      = r_qos;
    unique case (r_state)
      CALC: begin
        if (r_calc_cnt == '0) w_state_nxt = SAMPLE;
        else                  w_calc_cnt_nxt = r_calc_cnt - CW'(1);
      end
      SAMPLE: begin
        if (w_cand_ok) begin
          w_sel_nxt   = w_cand_sel;
          w_qos_nxt   = s_qos_i[w_cand_sel];
          w_state_nxt = XFER;
        end else begin
          w_state_nxt    = CALC;
          w_calc_cnt_nxt = CW'(TREE_LAT);
        end
      end
      XFER: begin
        if (w_m_valid && m_ready_i && w_m_last) begin
          w_state_nxt    = CALC;
          w_calc_cnt_nxt = CW'(TREE_LAT);
        end
      end
      default: begin
        w_state_nxt    = CALC;
        w_calc_cnt_nxt = CW'(TREE_LAT);
      end
    endcase
  end

  // rst_n is an active-high asynchronous reset in this codebase
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= CALC;
      r_calc_cnt <= CW'(TREE_LAT);
      r_sel      <= '0;
      r_qos      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_calc_cnt <= w_calc_cnt_nxt;
      r_sel      <= w_sel_nxt;
      r_qos      <= w_qos_nxt;
    end
  end

  stream_mux #(
    .T_DATA_WIDTH (T_DATA_WIDTH),
    .STREAM_COUNT (STREAM_COUNT),
    .SW           (SW)
  ) u_mux (
    .i_en      (w_xfer),
    .i_sel     (r_sel),
    .i_s_data  (s_data_i),
    .i_s_last  (s_last_i),
    .i_s_valid (s_valid_i),
    .i_m_ready (m_ready_i),
    .o_m_data  (w_m_data),
    .o_m_last  (w_m_last),
    .o_m_valid (w_m_valid),
    .o_s_ready (s_ready_o)
  );

  // Grant is derived from the registered state, so it rises on SAMPLE->XFER
  // and falls on XFER->CALC without a separate flag register
  always_comb begin
    in_serv_o = '0;
    if (w_xfer) in_serv_o[r_sel] = 1'b1;
  end

  assign can_calc_o = (r_state == CALC) && !rst_n;
  assign m_data_o   = w_m_data;
  assign m_last_o   = w_m_last;
  assign m_valid_o  = w_m_valid;
  assign m_qos_o    = w_xfer ? r_qos : '0;
  assign m_id_o     = w_xfer ? r_sel : '0;

endmodule

// File: tb/tb_stream_grant_ctrl.sv
// Scoreboard bench for stream_grant_ctrl with a registered comparator-tree
// model, per-stream packet sources and a decoupled output monitor.
module tb_stream_grant_ctrl;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [3:0] qos;
  } beat_t;

  typedef struct {
    int cyc;
    int id;
  } hs_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [1:0][7:0]  s_data;
  logic [1:0][3:0]  s_qos;
  logic [1:0]       s_last;
  logic [1:0]       s_valid;
  logic [1:0]       s_ready;
  logic [1:0]       win_idx;
  logic [1:0]       win_idx0;
  logic             can_calc;
  logic [1:0]       in_serv;
  logic [7:0]       m_data;
  logic [3:0]       m_qos;
  logic [0:0]       m_id;
  logic             m_last;
  logic             m_valid;
  logic             m_ready;

  stream_grant_ctrl #(
    .T_DATA_WIDTH (8),
    .T_QOS__WIDTH (4),
    .STREAM_COUNT (2),
    .TREE_LAT     (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data_i     (s_data),
    .s_qos_i      (s_qos),
    .s_last_i     (s_last),
    .s_valid_i    (s_valid),
    .s_ready_o    (s_ready),
    .win_index_i  (win_idx),
    .win_index0_i (win_idx0),
    .can_calc_o   (can_calc),
    .in_serv_o    (in_serv),
    .m_data_o     (m_data),
    .m_qos_o      (m_qos),
    .m_id_o       (m_id),
    .m_last_o     (m_last),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready)
  );

  always #5 clk = ~clk;

  int    n_checks = 0;
  int    n_pass   = 0;
  int    cyc      = 0;
  int    rel      = 0;
  beat_t src_q[2][$];
  beat_t exp_q[2][$];
  hs_t   hs_log[$];
  bit    bubbles  = 1'b0;
  bit    rdy_rand = 1'b0;
  bit    rdy_hold = 1'b0;
  bit    mid[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_beat(input int s, input logic [7:0] d, input bit last, input logic [3:0] q);
    beat_t b;
    b.data = d; b.last = last; b.qos = q;
    src_q[s].push_back(b);
    exp_q[s].push_back(b);
  endtask

  task automatic push_pkt(input int s, input logic [3:0] q, input int len);
    for (int i = 0; i < len; i++)
      push_beat(s, 8'($urandom_range(0, 255)), (i == len - 1), q);
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while ((exp_q[0].size() + exp_q[1].size()) != 0 && n < bound) begin
      @(negedge clk); #1;
      n++;
    end
    check("drain", 32'(exp_q[0].size() + exp_q[1].size()), 32'd0);
  endtask

  task automatic wait_log(input int cnt, input int bound);
    int n = 0;
    while (hs_log.size() < cnt && n < bound) begin
      @(negedge clk); #1;
      n++;
    end
    check("handshake_wait", 32'(hs_log.size() >= cnt), 32'd1);
  endtask

  task automatic release_rst();
    @(posedge clk); #2;
    rst_n = 1'b0;
    rel = cyc;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Registered comparator-tree model: evaluates only while can_calc is high
  initial begin
    bit       cc_s;
    int       best;
    logic [1:0] w, w0;
    win_idx  = 2'd2;
    win_idx0 = 2'd2;
    forever begin
      @(negedge clk);
      cc_s = can_calc;
      w = 2'd2; w0 = 2'd2; best = -1;
      for (int i = 1; i >= 0; i--)
        if (s_valid[i] && s_qos[i] == 4'd0) w0 = 2'(i);
      for (int i = 0; i < 2; i++)
        if (s_valid[i] && int'(s_qos[i]) > best) begin
          best = int'(s_qos[i]);
          w = 2'(i);
        end
      @(posedge clk); #1;
      if (cc_s) begin
        win_idx  = w;
        win_idx0 = w0;
      end
    end
  end

  // Per-stream sources plus master ready driver
  initial begin
    bit    hs[2];
    beat_t b;
    s_valid = '0; s_data = '0; s_last = '0; s_qos = '0; m_ready = 1'b1;
    mid[0] = 1'b0; mid[1] = 1'b0;
    forever begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) hs[s] = s_valid[s] & s_ready[s];
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        if (hs[s] && src_q[s].size() > 0) begin
          b = src_q[s].pop_front();
          mid[s] = !b.last;
        end
        if (src_q[s].size() > 0) begin
          b = src_q[s][0];
          s_data[s]  = b.data;
          s_last[s]  = b.last;
          s_qos[s]   = b.qos;
          s_valid[s] = (mid[s] && bubbles) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end else begin
          s_valid[s] = 1'b0;
          s_last[s]  = 1'b0;
        end
      end
      m_ready = rdy_hold ? 1'b0 : (rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    end
  end

  // Monitor: pops the expected beat of the presented stream on every handshake
  initial begin
    bit         pst = 1'b0;
    logic [7:0] pdata;
    int         pid = 0;
    int         id;
    beat_t      e;
    forever begin
      @(negedge clk);
      if (rst_n) pst = 1'b0;
      else if (m_valid) begin
        id = int'(m_id);
        check("in_serv_onehot", 32'(in_serv), 32'(1 << id));
        check("s_ready_route", 32'(s_ready), m_ready ? 32'(1 << id) : 32'd0);
        if (pst && pid == id) check("stall_data_stable", 32'(m_data), 32'(pdata));
        if (exp_q[id].size() == 0) check("spurious_beat", 32'(m_valid), 32'd0);
        else begin
          e = exp_q[id][0];
          check("m_data", 32'(m_data), 32'(e.data));
          check("m_last", 32'(m_last), 32'(e.last));
          check("m_qos", 32'(m_qos), 32'(e.qos));
          if (m_ready) begin
            void'(exp_q[id].pop_front());
            hs_log.push_back('{cyc, id});
          end
        end
        pst = !m_ready; pdata = m_data; pid = id;
      end else pst = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit cc[12];
    bit is1[8];
    int mv_cnt, p, ncnt, n;
    logic [7:0] d[4];

    // Reset values while reset is held (stream 1 already presenting data)
    push_beat(1, 8'hAA, 1'b0, 4'd5);
    push_beat(1, 8'hBB, 1'b0, 4'd5);
    push_beat(1, 8'hCC, 1'b1, 4'd5);
    repeat (3) @(negedge clk);
    check("rst_can_calc", 32'(can_calc), 32'd0);
    check("rst_in_serv", 32'(in_serv), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_last", 32'(m_last), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_m_qos", 32'(m_qos), 32'd0);
    check("rst_m_id", 32'(m_id), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd0);

    // First packet: CALC, CALC, SAMPLE, then XFER from cycle 3
    release_rst();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cc[k]  = can_calc;
      is1[k] = (in_serv == 2'b10);
      if (k == 2) check("first_sample_no_valid", 32'(m_valid), 32'd0);
      if (k == 2) check("first_sample_no_serv", 32'(in_serv), 32'd0);
      if (k == 3) begin
        check("first_xfer_valid", 32'(m_valid), 32'd1);
        check("first_xfer_id", 32'(m_id), 32'd1);
        check("first_xfer_qos", 32'(m_qos), 32'd5);
      end
    end
    check("calc_c0", 32'(cc[0]), 32'd1);
    check("calc_c1", 32'(cc[1]), 32'd1);
    check("calc_c2", 32'(cc[2]), 32'd0);
    check("calc_c3", 32'(cc[3]), 32'd0);
    for (int k = 3; k < 6; k++) check("in_serv_during_pkt", 32'(is1[k]), 32'd1);
    check("in_serv_cleared", 32'(is1[6]), 32'd0);
    wait_drain(50);

    // Idle: CALC/SAMPLE loop with can_calc 1,1,0 per round
    repeat (2) @(negedge clk);
    mv_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      cc[k] = can_calc;
      if (m_valid) mv_cnt++;
    end
    p = 0;
    for (int k = 2; k >= 0; k--) if (!cc[k]) p = k;
    for (int k = 0; k < 9; k++) check("idle_can_calc", 32'(cc[p+k]), (k % 3 == 0) ? 32'd0 : 32'd1);
    check("idle_no_valid", 32'(mv_cnt), 32'd0);

    // Zero-QoS precedence, then a 3-cycle gap before the other stream
    hs_log.delete();
    push_pkt(0, 4'd0, 2);
    push_pkt(1, 4'd9, 2);
    wait_drain(100);
    if (hs_log.size() == 4) begin
      check("zero_qos_first", 32'(hs_log[0].id), 32'd0);
      check("second_stream", 32'(hs_log[2].id), 32'd1);
      check("inter_pkt_gap", 32'(hs_log[2].cyc - hs_log[1].cyc), 32'd4);
    end else check("zero_qos_beats", 32'(hs_log.size()), 32'd4);

    // Max-QoS selection when no stream has zero QoS
    hs_log.delete();
    push_pkt(0, 4'd2, 1);
    push_pkt(1, 4'd7, 1);
    wait_drain(100);
    if (hs_log.size() == 2) begin
      check("max_qos_first", 32'(hs_log[0].id), 32'd1);
      check("max_qos_second", 32'(hs_log[1].id), 32'd0);
    end else check("max_qos_beats", 32'(hs_log.size()), 32'd2);

    // Downstream stall of 4 cycles mid-packet
    hs_log.delete();
    for (int i = 0; i < 4; i++) d[i] = 8'(8'h30 + i);
    for (int i = 0; i < 4; i++) push_beat(0, d[i], (i == 3), 4'd3);
    wait_log(2, 100);
    rdy_hold = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("stall_valid", 32'(m_valid), 32'd1);
      check("stall_s_ready", 32'(s_ready), 32'd0);
      check("stall_data", 32'(m_data), 32'(d[2]));
    end
    rdy_hold = 1'b0;
    wait_drain(100);
    check("stall_beat_count", 32'(hs_log.size()), 32'd4);

    // Back-to-back single-beat packets: one beat every 4 cycles
    hs_log.delete();
    for (int i = 0; i < 4; i++) push_beat(0, 8'(8'h50 + i), 1'b1, 4'd3);
    ncnt = 0; n = 0;
    do begin
      @(negedge clk); #1;
      if (in_serv[0]) ncnt++;
      n++;
    end while (hs_log.size() < 4 && n < 100);
    check("single_in_serv_cycles", 32'(ncnt), 32'd4);
    if (hs_log.size() == 4)
      for (int i = 0; i < 3; i++)
        check("single_spacing", 32'(hs_log[i+1].cyc - hs_log[i].cyc), 32'd4);
    else check("single_beats", 32'(hs_log.size()), 32'd4);
    wait_drain(50);

    // Reset pulsed during beat 2 of 4; packet truncated, fresh arbitration after
    hs_log.delete();
    push_pkt(1, 4'd6, 4);
    wait_log(1, 100);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    check("midrst_m_valid", 32'(m_valid), 32'd0);
    check("midrst_in_serv", 32'(in_serv), 32'd0);
    check("midrst_can_calc", 32'(can_calc), 32'd0);
    src_q[1].delete();
    exp_q[1].delete();
    mid[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_hold_valid", 32'(m_valid), 32'd0);
    release_rst();
    @(negedge clk);
    check("post_rst_can_calc", 32'(can_calc), 32'd1);
    check("post_rst_m_valid", 32'(m_valid), 32'd0);
    push_pkt(0, 4'd1, 2);
    wait_drain(100);
    if (hs_log.size() == 3) check("post_rst_stream", 32'(hs_log[2].id), 32'd0);
    else check("post_rst_beats", 32'(hs_log.size()), 32'd3);

    // Randomized traffic with source bubbles and downstream backpressure
    bubbles  = 1'b1;
    rdy_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      push_pkt($urandom_range(0, 1), 4'($urandom_range(0, 15)), $urandom_range(1, 4));
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_drain(4000);
    bubbles  = 1'b0;
    rdy_rand = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
